bias_group_scheduler: RTL

Sequences per-output-channel-group bias addition for one convolution layer. It sits between the 16-lane adder-tree output and the activation/requant stage. The block accepts a stream of adder-tree partial results and walks through N_GROUPS bias banks, one per 16-channel output group. Each lane gets its bias added with saturation, and results pass out through a registered valid/ready stage.

---
 rtl/bias_group_scheduler_pkg.sv | 21 ++
 rtl/bias_group_scheduler_if.sv | 23 ++
 rtl/bias_sat_add.sv | 27 ++
 rtl/bias_group_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bias_group_scheduler_pkg.sv
// Shared layer constants, state encoding and saturation limits for the
// bias group scheduler.
package bias_group_scheduler_pkg;

  localparam int W            = 18;
  localparam int N_ADDER_TREE = 16;
  localparam int N_GROUPS     = 4;
  localparam int GW           = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int BEAT_BITS    = N_ADDER_TREE * W;
  localparam int BANK_BITS    = N_GROUPS * BEAT_BITS;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/bias_group_scheduler_if.sv
// Adder-tree input stream and biased output stream of the bias group scheduler.
interface bias_group_scheduler_if;
  import bias_group_scheduler_pkg::*;

  logic                 acc_valid;
  logic                 acc_ready;
  logic [BEAT_BITS-1:0] acc_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BEAT_BITS-1:0] out_data;
  logic [GW-1:0]        group_idx;

  modport slave (
    input  acc_valid, acc_data, out_ready,
    output acc_ready, out_valid, out_data, group_idx
  );

  modport master (
    output acc_valid, acc_data, out_ready,
    input  acc_ready, out_valid, out_data, group_idx
  );

endinterface

// File: rtl/bias_sat_add.sv
// Single-lane signed W-bit adder that clamps to the representable range
// instead of wrapping.
module bias_sat_add
  import bias_group_scheduler_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] sum_s;

  // Overflow shows up as disagreement between the two top bits of the W+1-bit sum.
  always_comb begin
    sum_s = {a[W-1], a} + {b[W-1], b};
    if (sum_s[W] != sum_s[W-1]) begin
      if (sum_s[W] == 1'b0) begin
        y = SAT_MAX;
      end else begin
        y = SAT_MIN;
      end
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/bias_group_scheduler.sv
// Walks the bias banks group by group, adding each group's bias to the
// adder-tree beats and presenting the results through one output register.
module bias_group_scheduler
  import bias_group_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           pix_per_group,
  input  logic [BANK_BITS-1:0]  bias_bank,
  output logic                  busy,
  output logic                  done,
  bias_group_scheduler_if.slave bus
);

  state_e               state_q, state_d;
  logic [GW-1:0]        g_q, g_d;
  logic [15:0]          p_q, p_d;
  logic [15:0]          ppg_q, ppg_d;
  logic                 out_valid_q, out_valid_d;
  logic [BEAT_BITS-1:0] out_data_q, out_data_d;
  logic [GW-1:0]        group_idx_q, group_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 drain_s, acc_ready_s, accept_s, start_ok_s, last_beat_s;
  logic [BEAT_BITS-1:0] bank_s, sum_s;

  assign bank_s = bias_bank[g_q*BEAT_BITS +: BEAT_BITS];

  for (genvar i = 0; i < N_ADDER_TREE; i++) begin : g_lane
    bias_sat_add u_add (
      .a (bus.acc_data[i*W +: W]),
      .b (bank_s[i*W +: W]),
      .y (sum_s[i*W +: W])
    );
  end

  assign last_beat_s = (g_q == GW'(N_GROUPS - 1)) && (p_q == ppg_q - 16'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && last_beat_s) state_d = ST_FLUSH;
        else                         state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (drain_s) state_d = ST_IDLE;
        else         state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; a zero-length layer completes straight from IDLE.
  always_comb begin
    drain_s     = !out_valid_q || bus.out_ready;
    acc_ready_s = (state_q == ST_RUN) && drain_s;
    accept_s    = bus.acc_valid && acc_ready_s;
    start_ok_s  = (state_q == ST_IDLE) && start && (pix_per_group != 16'd0);
    done_d      = ((state_q == ST_IDLE) && start && (pix_per_group == 16'd0)) ||
                  ((state_q == ST_FLUSH) && drain_s);
    if (start_ok_s) begin
      busy_d = 1'b1;
    end else if ((state_q == ST_FLUSH) && drain_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // Group/pixel counters and the output register.
  always_comb begin
    g_d         = g_q;
    p_d         = p_q;
    ppg_d       = ppg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    group_idx_d = group_idx_q;
    if (start_ok_s) begin
      g_d   = {GW{1'b0}};
      p_d   = 16'd0;
      ppg_d = pix_per_group;
    end else if (accept_s) begin
      if (p_q == ppg_q - 16'd1) begin
        p_d = 16'd0;
        g_d = g_q + 1'b1;
      end else begin
        p_d = p_q + 16'd1;
      end
    end else begin
      p_d = p_q;
    end
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_s;
      group_idx_d = g_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q         <= {GW{1'b0}};
      p_q         <= 16'd0;
      ppg_q       <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {BEAT_BITS{1'b0}};
      group_idx_q <= {GW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      g_q         <= g_d;
      p_q         <= p_d;
      ppg_q       <= ppg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      group_idx_q <= group_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.acc_ready = acc_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.group_idx = group_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
